mode_sequencer: RTL and testbench

Parametrised time-setting mode sequencer for the clock. It replaces the fixed three-field adjust-mode controller with a NUM_FIELDS-wide one-hot field walk. It adds a cancel input, an inactivity timeout and an abort strobe. It sits between the debounced front-panel buttons and the timer/adjuster counter banks, and it drives their load strobes and the display register select.

---
 rtl/clock_pkg.sv | 13 +
 rtl/rise_detect.sv | 28 ++
 rtl/mode_sequencer.sv | 142 ++++++++++++++
 tb/tb_mode_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the time-setting mode sequencer.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_ADJ_LOAD   = 2'd1,
        ST_ADJUST     = 2'd2,
        ST_TIMER_LOAD = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT_TICKS = 30;

endpackage

// File: rtl/rise_detect.sv
// Registered-previous-value rising-edge detector.
module rise_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/mode_sequencer.sv
// Time-setting mode sequencer: one-hot field walk with load handshakes,
// cancel, and an idle-tick inactivity timeout.
module mode_sequencer
    import clock_pkg::*;
#(
    parameter int unsigned NUM_FIELDS    = 3,
    parameter int unsigned TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS,
    localparam int unsigned TIMEOUT_W    = (TIMEOUT_TICKS == 0) ? 1 : $clog2(TIMEOUT_TICKS + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  next_mode,
    input  logic                  cancel,
    input  logic                  activity,
    input  logic                  idle_tick,
    input  logic                  timer_clk,
    input  logic                  adjuster_clk,
    output logic                  timer_load,
    output logic                  adjuster_load,
    output logic                  reg_select,
    output logic [NUM_FIELDS-1:0] adjust_mode,
    output logic                  adjust_aborted
);

    localparam logic [NUM_FIELDS-1:0] FIELD0     = NUM_FIELDS'(1) << (NUM_FIELDS - 1);
    localparam logic [TIMEOUT_W-1:0]  T_LAST     = TIMEOUT_W'(TIMEOUT_TICKS - 1);
    localparam logic [TIMEOUT_W-1:0]  T_MAX      = TIMEOUT_W'(TIMEOUT_TICKS);
    localparam logic                  TIMEOUT_EN = (TIMEOUT_TICKS != 0);

    logic next_rise, cancel_rise, timer_rise, adj_rise;

    // Buttons held through reset must not register as a press.
    rise_detect #(.RESET_VAL(1'b1)) u_next_rise (
        .clk(clk), .reset_n(reset_n), .d(next_mode), .rise(next_rise));
    rise_detect #(.RESET_VAL(1'b1)) u_cancel_rise (
        .clk(clk), .reset_n(reset_n), .d(cancel), .rise(cancel_rise));
    rise_detect #(.RESET_VAL(1'b0)) u_timer_rise (
        .clk(clk), .reset_n(reset_n), .d(timer_clk), .rise(timer_rise));
    rise_detect #(.RESET_VAL(1'b0)) u_adj_rise (
        .clk(clk), .reset_n(reset_n), .d(adjuster_clk), .rise(adj_rise));

    state_e                  state_q, state_d;
    logic [NUM_FIELDS-1:0]   mode_q, mode_d;
    logic                    timer_load_q, timer_load_d;
    logic                    adjuster_load_q, adjuster_load_d;
    logic                    reg_select_q, reg_select_d;
    logic                    aborted_q, aborted_d;
    logic [TIMEOUT_W-1:0]    cnt_q, cnt_d;
    logic                    expire;

    // Activity in the same cycle as a tick clears rather than expires.
    assign expire = TIMEOUT_EN && idle_tick && !activity && (cnt_q == T_LAST);

    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        timer_load_d    = timer_load_q;
        adjuster_load_d = adjuster_load_q;
        aborted_d       = 1'b0;
        cnt_d           = cnt_q;

        case (state_q)
            ST_RUN: begin
                mode_d          = '0;
                timer_load_d    = 1'b0;
                adjuster_load_d = 1'b0;
                cnt_d           = '0;
                if (next_rise) begin
                    adjuster_load_d = 1'b1;
                    state_d         = ST_ADJ_LOAD;
                end
            end
            ST_ADJ_LOAD: begin
                if (adj_rise) begin
                    adjuster_load_d = 1'b0;
                    mode_d          = FIELD0;
                    cnt_d           = '0;
                    state_d         = ST_ADJUST;
                end
            end
            ST_ADJUST: begin
                if (activity || next_rise) begin
                    cnt_d = '0;
                end else if (idle_tick && (cnt_q != T_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end

                if (cancel_rise || expire) begin
                    mode_d    = '0;
                    aborted_d = 1'b1;
                    state_d   = ST_RUN;
                end else if (next_rise) begin
                    if (mode_q[0]) begin
                        timer_load_d = 1'b1;
                        state_d      = ST_TIMER_LOAD;
                    end else begin
                        mode_d = mode_q >> 1;
                    end
                end
            end
            ST_TIMER_LOAD: begin
                if (timer_rise) begin
                    timer_load_d = 1'b0;
                    mode_d       = '0;
                    state_d      = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        reg_select_d = |mode_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_RUN;
            mode_q          <= '0;
            timer_load_q    <= 1'b0;
            adjuster_load_q <= 1'b0;
            reg_select_q    <= 1'b0;
            aborted_q       <= 1'b0;
            cnt_q           <= '0;
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            timer_load_q    <= timer_load_d;
            adjuster_load_q <= adjuster_load_d;
            reg_select_q    <= reg_select_d;
            aborted_q       <= aborted_d;
            cnt_q           <= cnt_d;
        end
    end

    assign timer_load     = timer_load_q;
    assign adjuster_load  = adjuster_load_q;
    assign reg_select     = reg_select_q;
    assign adjust_mode    = mode_q;
    assign adjust_aborted = aborted_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed-vector bench for mode_sequencer: 3-field/timeout-4, 5-field/no-timeout
// and 1-field instances driven from shared stimulus.
module tb_mode_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    logic next_mode, cancel, activity, idle_tick, timer_clk, adjuster_clk;

    logic       tl_a, al_a, rs_a, ab_a;
    logic [2:0] mode_a;
    logic       tl_b, al_b, rs_b, ab_b;
    logic [4:0] mode_b;
    logic       tl_c, al_c, rs_c, ab_c;
    logic [0:0] mode_c;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    mode_sequencer #(.NUM_FIELDS(3), .TIMEOUT_TICKS(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .next_mode(next_mode), .cancel(cancel),
        .activity(activity), .idle_tick(idle_tick), .timer_clk(timer_clk),
        .adjuster_clk(adjuster_clk), .timer_load(tl_a), .adjuster_load(al_a),
        .reg_select(rs_a), .adjust_mode(mode_a), .adjust_aborted(ab_a));

    mode_sequencer #(.NUM_FIELDS(5), .TIMEOUT_TICKS(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .next_mode(next_mode), .cancel(cancel),
        .activity(activity), .idle_tick(idle_tick), .timer_clk(timer_clk),
        .adjuster_clk(adjuster_clk), .timer_load(tl_b), .adjuster_load(al_b),
        .reg_select(rs_b), .adjust_mode(mode_b), .adjust_aborted(ab_b));

    mode_sequencer #(.NUM_FIELDS(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .next_mode(next_mode), .cancel(cancel),
        .activity(activity), .idle_tick(idle_tick), .timer_clk(timer_clk),
        .adjuster_clk(adjuster_clk), .timer_load(tl_c), .adjuster_load(al_c),
        .reg_select(rs_c), .adjust_mode(mode_c), .adjust_aborted(ab_c));

    // inputs {next_mode, cancel, activity, idle_tick, timer_clk, adjuster_clk}
    // expected {timer_load, adjuster_load, reg_select, adjust_mode[2:0], adjust_aborted}
    typedef struct packed {
        logic [5:0] in;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [6:0] out_a();
        return {tl_a, al_a, rs_a, mode_a, ab_a};
    endfunction

    function automatic logic [8:0] out_b();
        return {tl_b, al_b, rs_b, mode_b, ab_b};
    endfunction

    function automatic logic [4:0] out_c();
        return {tl_c, al_c, rs_c, mode_c, ab_c};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        next_mode = 0; cancel = 0; activity = 0;
        idle_tick = 0; timer_clk = 0; adjuster_clk = 0;
    endtask

    task automatic pulse_nm();
        next_mode = 1; step();
        next_mode = 0; step();
    endtask

    task automatic do_reset();
        reset_n = 0;
        step();
        step();
        reset_n = 1;
        step();
    endtask

    task automatic add(input logic [5:0] in, input logic [6:0] exp);
        tbl.push_back('{in: in, exp: exp});
    endtask

    initial begin
        // main walk
        add(6'b000000, 7'b0_0_0_000_0);
        add(6'b100000, 7'b0_1_0_000_0);
        add(6'b000000, 7'b0_1_0_000_0);
        add(6'b010000, 7'b0_1_0_000_0);
        add(6'b000001, 7'b0_0_1_100_0);
        add(6'b100000, 7'b0_0_1_010_0);
        add(6'b000000, 7'b0_0_1_010_0);
        add(6'b100000, 7'b0_0_1_001_0);
        add(6'b000000, 7'b0_0_1_001_0);
        add(6'b100000, 7'b1_0_1_001_0);
        add(6'b000010, 7'b0_0_0_000_0);
        add(6'b000000, 7'b0_0_0_000_0);
        // bank-clock edge coincident with strobe rise is not seen
        add(6'b100001, 7'b0_1_0_000_0);
        add(6'b000000, 7'b0_1_0_000_0);
        add(6'b000001, 7'b0_0_1_100_0);
        add(6'b000000, 7'b0_0_1_100_0);
        add(6'b100000, 7'b0_0_1_010_0);
        add(6'b000000, 7'b0_0_1_010_0);
        // cancel and next_mode together at field 1
        add(6'b110000, 7'b0_0_0_000_1);
        add(6'b000000, 7'b0_0_0_000_0);
        // timeout with activity+tick clearing after tick 3
        add(6'b100000, 7'b0_1_0_000_0);
        add(6'b000001, 7'b0_0_1_100_0);
        add(6'b000100, 7'b0_0_1_100_0);
        add(6'b000000, 7'b0_0_1_100_0);
        add(6'b000100, 7'b0_0_1_100_0);
        add(6'b000100, 7'b0_0_1_100_0);
        add(6'b001100, 7'b0_0_1_100_0);
        add(6'b000100, 7'b0_0_1_100_0);
        add(6'b000100, 7'b0_0_1_100_0);
        add(6'b000100, 7'b0_0_1_100_0);
        add(6'b000100, 7'b0_0_0_000_1);
        add(6'b000000, 7'b0_0_0_000_0);
        // plain timeout on the 4th tick
        add(6'b100000, 7'b0_1_0_000_0);
        add(6'b000001, 7'b0_0_1_100_0);
        add(6'b000100, 7'b0_0_1_100_0);
        add(6'b000100, 7'b0_0_1_100_0);
        add(6'b000100, 7'b0_0_1_100_0);
        add(6'b000100, 7'b0_0_0_000_1);
        add(6'b000000, 7'b0_0_0_000_0);

        clear_inputs();
        do_reset();
        chk("reset_a", 32'(out_a()), 32'd0);
        chk("reset_b", 32'(out_b()), 32'd0);
        chk("reset_c", 32'(out_c()), 32'd0);

        foreach (tbl[i]) begin
            {next_mode, cancel, activity, idle_tick, timer_clk, adjuster_clk} = tbl[i].in;
            step();
            chk($sformatf("vec%0d", i), 32'(out_a()), 32'(tbl[i].exp));
        end

        // 5-field and 1-field walks
        clear_inputs();
        do_reset();
        next_mode = 1; step();
        chk("b_adj_load", 32'(out_b()), 32'(9'b0_1_0_00000_0));
        chk("c_adj_load", 32'(out_c()), 32'(5'b0_1_0_0_0));
        next_mode = 0; step();
        adjuster_clk = 1; step();
        adjuster_clk = 0;
        chk("b_field0", 32'(out_b()), 32'(9'b0_0_1_10000_0));
        chk("c_field0", 32'(out_c()), 32'(5'b0_0_1_1_0));
        repeat (10) begin
            idle_tick = 1; step();
            idle_tick = 0; step();
        end
        chk("b_no_timeout", 32'(out_b()), 32'(9'b0_0_1_10000_0));
        for (int k = 1; k <= 4; k++) begin
            logic [4:0] m;
            m = 5'b10000 >> k;
            pulse_nm();
            chk($sformatf("b_field%0d", k), 32'(out_b()), 32'({3'b001, m, 1'b0}));
            if (k == 1) chk("c_timer_load", 32'(out_c()), 32'(5'b1_0_1_1_0));
        end
        pulse_nm();
        chk("b_timer_load", 32'(out_b()), 32'(9'b1_0_1_00001_0));
        timer_clk = 1; step();
        timer_clk = 0;
        chk("b_done", 32'(out_b()), 32'd0);
        chk("c_done", 32'(out_c()), 32'd0);

        // next_mode held through reset release
        clear_inputs();
        next_mode = 1;
        do_reset();
        step();
        step();
        chk("held_nm_run", 32'(out_a()), 32'd0);
        next_mode = 0; step();
        next_mode = 1; step();
        chk("nm_after_release", 32'(out_a()), 32'(7'b0_1_0_000_0));

        // asynchronous reset in TIMER_LOAD
        next_mode = 0;
        adjuster_clk = 1; step();
        adjuster_clk = 0;
        pulse_nm();
        pulse_nm();
        pulse_nm();
        chk("a_timer_load", 32'(out_a()), 32'(7'b1_0_1_001_0));
        #2 reset_n = 0;
        #1;
        chk("async_reset_a", 32'(out_a()), 32'd0);
        reset_n = 1;
        step();
        chk("after_reset_a", 32'(out_a()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
